// File: rtl/bcd_to_excess3_serial.sv
// bcd_to_excess3_serial
// Multi-digit BCD to excess-3 encoder. A packed BCD word is accepted on a
// valid/ready handshake. The word is converted in place one digit per clock,
// starting with digit 0. The packed excess-3 result is then offered on a
// second valid/ready handshake.
//
// Optional build macro: BCD_ERR_CHECK_EN. When it is defined, err flags any
// input digit above 9 in the current word. When it is undefined, err is tied
// low and no range-check logic is built.
//
// Timing: the word is captured at edge k. Digits 0..DIGITS-1 are converted on
// edges k+1..k+DIGITS, so out_valid is high after edge k+DIGITS. Counting the
// capture edge itself, that is the (DIGITS+1)th edge. With out_ready held
// high, a new word is accepted every DIGITS+2 cycles (IDLE, DIGITS x CONV,
// DONE).

module bcd_to_excess3_serial #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*DIGITS-1:0] xs3_out,
    output logic              err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [DIGITS-1:0][3:0]   work;   // doubles as the result register
    logic [DIGITS-1:0][3:0]   conv;   // per-digit +3 (mod 16) of the working word

`ifdef BCD_ERR_CHECK_EN
    logic [DIGITS-1:0]        bad;    // per-digit "not a BCD digit" flag
    logic                     err_q;
`endif

    // Per-digit converters. Only the one selected by cnt is written back.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign conv[g] = work[g] + 4'd3;
`ifdef BCD_ERR_CHECK_EN
        assign bad[g]  = (work[g] > 4'd9);
`endif
    end

    // Handshake flags are decoded from state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign xs3_out   = work;

`ifdef BCD_ERR_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Control FSM, digit counter, in-place conversion and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
`ifdef BCD_ERR_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= bcd_in;
                        cnt   <= '0;
`ifdef BCD_ERR_CHECK_EN
                        err_q <= 1'b0;
`endif
                        state <= CONV;
                    end
                end
                CONV: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt == CW'(i)) begin
                            work[i] <= conv[i];
`ifdef BCD_ERR_CHECK_EN
                            // Check the raw digit before it is overwritten.
                            if (bad[i]) err_q <= 1'b1;
`endif
                        end
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    // Result and err hold here until the consumer takes them.
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
